// File: rtl/async_fifo_core.sv
// Single-clock FIFO of WIDTH-bit words, DEPTH entries; optional sticky error flags under FIFO_ERR_FLAGS_EN.
// Latency: data_out is registered and updates on the edge that accepts a pop; no fall-through when empty.
// Backpressure: push is ignored while full, pop is ignored while empty; both are level requests per edge.
module async_fifo_core #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      cnt_q,  cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             wr_en, rd_en;

    // Status flags are pure decodes of the occupancy count.
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_FULL);
    assign data_out = dout_q;

    // Accept logic and next-state for pointers, count and read register.
    always_comb begin
        wr_en  = push & ~full;
        rd_en  = pop & ~empty;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (wr_en) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_en) begin
            rptr_d = rptr_q + AW'(1);
            dout_d = mem_q[rptr_q];
        end
        case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state; reset empties the FIFO and clears the read register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    // Storage array: no reset, contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= data_in;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // Sticky error next-state: a rejected request latches its flag until reset.
    always_comb begin
        ovf_d = ovf_q | (push & full);
        unf_d = unf_q | (pop & empty);
    end

    // Sticky error flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_async_fifo_core.sv
// Bench for async_fifo_core: directed scenarios plus randomized traffic against a queue model.
// Inputs are driven on the falling edge, outputs compared on the following falling edge.
// Error-flag checks are compiled in only when FIFO_ERR_FLAGS_EN is defined.
module tb_async_fifo_core;

    logic        clk;
    logic        rst;
    logic        push;
    logic [31:0] data_in;
    logic        pop;
    logic [31:0] data_out;
    logic        empty;
    logic        full;
`ifdef FIFO_ERR_FLAGS_EN
    logic        overflow;
    logic        underflow;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: an unbounded queue limited to 8 entries by the model rules.
    logic [31:0] q[$];
    logic [31:0] exp_dout;
    bit          exp_ovf;
    bit          exp_unf;
    bit          last_rd;

    async_fifo_core dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .data_in  (data_in),
        .pop      (pop),
        .data_out (data_out),
        .empty    (empty),
        .full     (full)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        q.delete();
        exp_dout = 32'h0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
        last_rd  = 1'b0;
    endtask

    // One clock of stimulus; returns on the next falling edge with the model updated.
    task automatic step(input bit p, input logic [31:0] d, input bit r);
        bit was_full, was_empty;
        push    = p;
        data_in = d;
        pop     = r;
        @(posedge clk);
        was_full  = (q.size() == 8);
        was_empty = (q.size() == 0);
        last_rd   = r && !was_empty;
        if (last_rd) exp_dout = q.pop_front();
        if (p && !was_full) q.push_back(d);
        if (p && was_full) exp_ovf = 1'b1;
        if (r && was_empty) exp_unf = 1'b1;
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic test_reset();
        // Outputs must follow rst before any clock edge.
        #2;
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL reset_dout: got %h want 0", data_out); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1, 32'hA, 0);
        step(1, 32'hB, 0);
        step(0, 0, 1);
        total++; if (data_out !== 32'hA) begin bad++; $display("FAIL midrst_pre: got %h want a", data_out); end
        // Asynchronous reset between edges discards stored data immediately.
        #2 rst = 1'b1;
        #1;
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL midrst_dout: got %h want 0", data_out); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL midrst_empty: got %b want 1", empty); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 1);
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL midrst_nodata: got %h want 0", data_out); end
        // Clear sticky flags raised by the pop above.
        rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 3; i++) step(1, i, 0);
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL basic_nonempty: got %b want 0", empty); end
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 1);
            total++; if (data_out !== 32'(i)) begin bad++; $display("FAIL basic_pop%0d: got %0d want %0d", i, data_out, i); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL basic_empty: got %b want 1", empty); end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 8; i++) begin
            step(1, i, 0);
            if (i == 7) begin
                total++; if (full !== 1'b0) begin bad++; $display("FAIL full_at7: got %b want 0", full); end
            end
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL full_at8: got %b want 1", full); end
        step(1, 9, 0);
        total++; if (full !== 1'b1) begin bad++; $display("FAIL full_drop: got %b want 1", full); end
`ifdef FIFO_ERR_FLAGS_EN
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_overflow: got %b want 1", overflow); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL full_underflow: got %b want 0", underflow); end
`endif
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 1);
            total++; if (data_out !== 32'(i)) begin bad++; $display("FAIL full_pop%0d: got %0d want %0d", i, data_out, i); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_drained: got %b want 1", empty); end
    endtask

    task automatic test_empty();
        step(0, 0, 1);
        total++; if (data_out !== 32'd8) begin bad++; $display("FAIL empty_hold: got %0d want 8", data_out); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL empty_flag: got %b want 1", empty); end
`ifdef FIFO_ERR_FLAGS_EN
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL empty_underflow: got %b want 1", underflow); end
`endif
        // Count must not have gone negative: one push then one pop empties it again.
        step(1, 32'h77, 0);
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL empty_push: got %b want 0", empty); end
        step(0, 0, 1);
        total++; if (data_out !== 32'h77) begin bad++; $display("FAIL empty_pop: got %h want 77", data_out); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL empty_again: got %b want 1", empty); end
    endtask

    task automatic test_simultaneous();
        for (int i = 5; i <= 8; i++) step(1, i, 0);
        step(1, 9, 1);
        total++; if (data_out !== 32'd5) begin bad++; $display("FAIL simul_dout: got %0d want 5", data_out); end
        total++; if (empty !== 1'b0 || full !== 1'b0) begin bad++; $display("FAIL simul_flags: got e=%b f=%b want e=0 f=0", empty, full); end
        for (int i = 6; i <= 9; i++) begin
            step(0, 0, 1);
            total++; if (data_out !== 32'(i)) begin bad++; $display("FAIL simul_pop%0d: got %0d want %0d", i, data_out, i); end
        end
        // Push+pop while empty: only the push happens, no fall-through.
        step(1, 32'h55, 1);
        total++; if (data_out !== 32'd9) begin bad++; $display("FAIL simul_empty_hold: got %0d want 9", data_out); end
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL simul_empty_flag: got %b want 0", empty); end
        step(0, 0, 1);
        total++; if (data_out !== 32'h55) begin bad++; $display("FAIL simul_empty_later: got %h want 55", data_out); end
        // Push+pop while full: only the pop happens.
        for (int i = 1; i <= 8; i++) step(1, 32'h100 + i, 0);
        step(1, 32'h1FF, 1);
        total++; if (data_out !== 32'h101) begin bad++; $display("FAIL simul_full_dout: got %h want 101", data_out); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL simul_full_flag: got %b want 0", full); end
        for (int i = 2; i <= 8; i++) begin
            step(0, 0, 1);
            total++; if (data_out !== 32'h100 + i) begin bad++; $display("FAIL simul_full_pop%0d: got %h want %h", i, data_out, 32'h100 + i); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL simul_full_drained: got %b want 1", empty); end
    endtask

    task automatic test_wrap();
        int next_in  = 1;
        int next_out = 1;
        int guard    = 0;
        while ((next_out <= 21) && (guard < 500)) begin
            bit p, r;
            p = (next_in <= 21) && (q.size() < 7);
            r = ($urandom_range(0, 1) == 1);
            step(p, next_in, r);
            if (p) next_in++;
            if (last_rd) begin
                total++; if (data_out !== 32'(next_out)) begin bad++; $display("FAIL wrap_order: got %0d want %0d", data_out, next_out); end
                next_out++;
            end
            total++; if (full !== 1'b0) begin bad++; $display("FAIL wrap_full: got %b want 0", full); end
            guard++;
        end
        total++; if (next_out != 22) begin bad++; $display("FAIL wrap_count: got %0d words want 21", next_out - 1); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty: got %b want 1", empty); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45);
            total++; if (data_out !== exp_dout) begin bad++; $display("FAIL rand_dout[%0d]: got %h want %h", i, data_out, exp_dout); end
            total++; if (empty !== (q.size() == 0)) begin bad++; $display("FAIL rand_empty[%0d]: got %b want %b", i, empty, q.size() == 0); end
            total++; if (full !== (q.size() == 8)) begin bad++; $display("FAIL rand_full[%0d]: got %b want %b", i, full, q.size() == 8); end
`ifdef FIFO_ERR_FLAGS_EN
            total++; if (overflow !== exp_ovf) begin bad++; $display("FAIL rand_ovf[%0d]: got %b want %b", i, overflow, exp_ovf); end
            total++; if (underflow !== exp_unf) begin bad++; $display("FAIL rand_unf[%0d]: got %b want %b", i, underflow, exp_unf); end
`endif
        end
    endtask

    initial begin
        rst     = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = 32'h0;
        model_reset();
        test_reset();
        test_basic();
        test_full();
        test_empty();
        test_simultaneous();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
